// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM states, default header byte and frame-length helper for the UART transmit framer
package uart_tx_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Header byte + one byte per data byte + optional checksum byte
    function automatic int frame_len(input int data_w, input bit csum_en);
        return data_w / 8 + 1 + (csum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// word_fifo: synchronous word FIFO feeding the UART transmit framer
//   clk, reset (async, active-low)
//   push/wr_data : write a word (ignored when full)
//   pop/rd_data  : rd_data is the head word; pop removes it (ignored when empty)
//   full, empty, level : occupancy, registered, updated on the edge after push/pop
module word_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              w_push;
    logic              w_pop;

    // Fullness is judged on the registered level, so a push in the same cycle
    // as a pop is refused whenever the FIFO was full at the start of the cycle.
    assign full    = r_level == (AW+1)'(DEPTH);
    assign empty   = r_level == '0;
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: buffers result words and sends each as a byte frame (header, data LSB first, optional checksum) to a UART transmitter
//   clk, reset (async, active-low)
//   res_data/res_valid/res_ready : word input, res_ready = FIFO not full
//   tx_start/tx_data/tx_done_tick : one-byte-at-a-time transmitter handshake
//   busy  : frame in progress
//   level : words held in the FIFO
//   Build option: define UART_TX_FRAMER_CHECKSUM_EN to append an XOR checksum byte
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int         DATA_W = 32,
    parameter int         DEPTH  = 4,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       res_data,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic                    tx_done_tick,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level
);

`ifdef UART_TX_FRAMER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int               FRAME_LEN = frame_len(DATA_W, CSUM_EN);
    localparam int               IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_head;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_tx_data;
    logic [7:0]        w_byte;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    word_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (res_valid && res_ready),
        .wr_data (res_data),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    assign res_ready = !w_full;
    assign busy      = r_state != S_IDLE;
    assign tx_data   = r_tx_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        tx_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop  = !w_empty;
                w_next = w_empty ? S_IDLE : S_LOAD;
            end
            S_LOAD:  w_next = S_START;
            S_START: begin
                tx_start = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT:  w_next = !tx_done_tick ? S_WAIT : (r_idx == LAST_IDX) ? S_IDLE : S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // Index 0 is the header slot; data bytes follow and are always taken from
    // the low byte of the shift register, which moves down after each one.
`ifdef UART_TX_FRAMER_CHECKSUM_EN
    logic [7:0] r_csum;

    assign w_byte = (r_idx == '0) ? HEADER : (r_idx == LAST_IDX) ? r_csum : r_shift[7:0];

    // Seeded with the header, folded with each data byte as it is loaded, so
    // it is complete by the time the checksum slot is loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_csum <= '0;
        else if (w_pop) r_csum <= HEADER;
        else if (r_state == S_LOAD && r_idx != '0 && r_idx != LAST_IDX) r_csum <= r_csum ^ r_shift[7:0];
    end
`else
    assign w_byte = (r_idx == '0) ? HEADER : r_shift[7:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
        end else begin
            if (w_pop) begin
                r_shift <= w_head;
                r_idx   <= '0;
            end else if (r_state == S_WAIT && tx_done_tick && r_idx != LAST_IDX) begin
                r_idx <= r_idx + 1'b1;
                if (r_idx != '0) r_shift <= r_shift >> 8;
            end
            if (r_state == S_LOAD) r_tx_data <= w_byte;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: self-checking bench for uart_tx_framer (32-bit and 8-bit instances)
module tb_uart_tx_framer;

`ifdef UART_TX_FRAMER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int         FL  = 5 + CS;
    localparam logic [7:0] HDR = 8'hA5;

    typedef struct packed {
        logic [31:0] word;
        logic [47:0] bytes;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] res_data = '0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic        tx_done_tick;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [2:0]  level;
    logic        resp_tick = 1'b0;
    logic        spur_tick = 1'b0;
    logic        auto_ack = 1'b1;
    int          dly = 0;

    logic [7:0]  d8_data = '0;
    logic        d8_valid = 1'b0;
    logic        d8_ready;
    logic        d8_tick = 1'b0;
    logic        d8_start;
    logic [7:0]  d8_tx;
    logic        d8_busy;
    logic [2:0]  d8_level;

    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    bit          prev_start = 1'b0;
    logic [7:0]  exp_q [$];
    vec_t        tbl [4];

    assign tx_done_tick = resp_tick | spur_tick;

    always #5 clk = ~clk;

    uart_tx_framer dut (
        .clk          (clk),
        .reset        (reset),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .level        (level)
    );

    uart_tx_framer #(.DATA_W(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .res_data     (d8_data),
        .res_valid    (d8_valid),
        .res_ready    (d8_ready),
        .tx_done_tick (d8_tick),
        .tx_start     (d8_start),
        .tx_data      (d8_tx),
        .busy         (d8_busy),
        .level        (d8_level)
    );

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
        errors++;
        $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) fail(name, act, req);
    endtask

    // Reference frame: header, bytes LSB first, then XOR of everything before it.
    task automatic model_word(input logic [31:0] w);
        logic [7:0] cs;
        cs = HDR;
        exp_q.push_back(HDR);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(w >> (8 * i)));
            cs ^= 8'(w >> (8 * i));
        end
        if (CS == 1) exp_q.push_back(cs);
    endtask

    task automatic push(input logic [31:0] w, input bit model);
        int n;
        n = 0;
        res_data  = w;
        res_valid = 1'b1;
        while (!res_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!res_ready) begin
            checks++;
            fail("push_timeout", 32'(n), 0);
        end else if (model) model_word(w);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!tx_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_start) begin
            checks++;
            fail("start_timeout", 32'(n), 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bytes_left", 32'(exp_q.size()), 0);
        chk("drain_busy", 32'(busy), 0);
        chk("drain_level", 32'(level), 0);
    endtask

    // Push into an idle block at edge E: tx_start must be high only after E+2.
    task automatic latency(input logic [31:0] w, input bit spur);
        model_word(w);
        res_data  = w;
        res_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
        spur_tick = spur;
        chk("lat_e1", 32'(tx_start), 0);
        @(negedge clk);
        chk("lat_e2", 32'(tx_start), 0);
        @(negedge clk);
        spur_tick = 1'b0;
        chk("lat_e3", 32'(tx_start), 1);
        drain();
    endtask

    // Called in a START cycle: ack the byte, then expect tx_start after 'gap' more edges.
    task automatic ack_gap(input string name, input int gap);
        @(negedge clk);
        spur_tick = 1'b1;
        @(negedge clk);
        spur_tick = 1'b0;
        chk(name, 32'(tx_start), 0);
        for (int i = 1; i < gap; i++) begin
            @(negedge clk);
            chk(name, 32'(tx_start), 0);
        end
        if (gap > 0) begin
            @(negedge clk);
            chk(name, 32'(tx_start), 1);
        end
    endtask

    always @(negedge clk) begin
        if (reset && tx_start) begin
            start_cnt++;
            if (prev_start) begin
                checks++;
                fail("start_width", 2, 1);
            end
            if (exp_q.size() == 0) begin
                checks++;
                fail("unexpected_start", 32'(tx_data), 0);
            end else chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        prev_start = reset && tx_start;
    end

    always @(negedge clk) begin
        resp_tick = 1'b0;
        if (!reset) dly = 0;
        else begin
            if (dly > 0) begin
                dly--;
                if (dly == 0) resp_tick = 1'b1;
            end
            if (tx_start && auto_ack) dly = 3;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         s0;
        int         n;
        logic [7:0] b8;
        logic [23:0] d8_exp;
        tbl[0] = '{32'h11223344, 48'hA5_44_33_22_11_E1};
        tbl[1] = '{32'h00000000, 48'hA5_00_00_00_00_A5};
        tbl[2] = '{32'hFFFFFFFF, 48'hA5_FF_FF_FF_FF_A5};
        tbl[3] = '{32'hDEADBEEF, 48'hA5_EF_BE_AD_DE_87};
        d8_exp = 24'hA5_D5_70;

        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_res_ready", 32'(res_ready), 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            s0 = start_cnt;
            for (int b = 0; b < FL; b++) begin
                b8 = tbl[k].bytes[47 - 8 * b -: 8];
                exp_q.push_back(b8);
            end
            push(tbl[k].word, 1'b0);
            drain();
            chk("tbl_start_count", 32'(start_cnt - s0), 32'(FL));
        end

        latency(32'hCAFEF00D, 1'b0);
        latency(32'h0BADBEEF, 1'b1);

        s0 = start_cnt;
        spur_tick = 1'b1;
        @(negedge clk);
        spur_tick = 1'b0;
        chk("spur_idle_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        chk("spur_idle_starts", 32'(start_cnt - s0), 0);

        auto_ack = 1'b0;
        push(32'h01020304, 1'b1);
        push(32'hA0B0C0D0, 1'b1);
        wait_start();
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < FL; b++)
                ack_gap((b == FL - 1 && f == 0) ? "gap_frame" : "gap_byte",
                        (b < FL - 1) ? 1 : (f == 0 ? 2 : 0));
        auto_ack = 1'b1;
        drain();

        auto_ack = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h50000000 + 32'(i), 1'b1);
        chk("full_level", 32'(level), 4);
        chk("full_ready", 32'(res_ready), 0);
        res_data  = 32'hDEAD0000;
        res_valid = 1'b1;
        repeat (3) @(negedge clk);
        res_valid = 1'b0;
        chk("full_drop_level", 32'(level), 4);
        auto_ack  = 1'b1;
        @(negedge clk);
        spur_tick = 1'b1;
        @(negedge clk);
        spur_tick = 1'b0;
        drain();

        repeat (24) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push($urandom, 1'b1);
        end
        drain();

        s0 = start_cnt;
        for (int i = 0; i < 3; i++) push(32'h77000000 + 32'(i), 1'b1);
        n = 0;
        while (start_cnt < s0 + 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (start_cnt < s0 + 3) begin
            checks++;
            fail("rst_mid_timeout", 32'(start_cnt - s0), 3);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_tx_start", 32'(tx_start), 0);
        chk("rst_mid_tx_data", 32'(tx_data), 0);
        chk("rst_mid_level", 32'(level), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ready", 32'(res_ready), 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s0 = start_cnt;
        repeat (60) @(negedge clk);
        chk("rst_no_resume", 32'(start_cnt - s0), 0);
        chk("rst_idle_busy", 32'(busy), 0);

        d8_data  = 8'hD5;
        d8_valid = 1'b1;
        @(negedge clk);
        d8_valid = 1'b0;
        for (int b = 0; b < 2 + CS; b++) begin
            n = 0;
            while (!d8_start && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!d8_start) begin
                checks++;
                fail("d8_start_timeout", 32'(n), 0);
            end
            b8 = d8_exp[23 - 8 * b -: 8];
            chk("d8_byte", 32'(d8_tx), 32'(b8));
            repeat (2) @(negedge clk);
            d8_tick = 1'b1;
            @(negedge clk);
            d8_tick = 1'b0;
        end
        chk("d8_busy", 32'(d8_busy), 0);
        chk("d8_level", 32'(d8_level), 0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (d8_start) n++;
        end
        chk("d8_no_extra", 32'(n), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
